// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised external interrupt controller; define IRQ_EDGE_EN for rising-edge pending instead of level.
module irq_ctrl #(
  parameter int N_IRQ = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_we,
  input  logic [31:0]      i_addr,
  input  logic [31:0]      i_data,
  output logic [31:0]      o_data,
  input  logic             i_int_ack,
  input  logic             i_eret,
  output logic             o_interrupt,
  output logic [4:0]       o_irq_id,
  output logic             o_busy
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t r_state, w_next;
  logic [N_IRQ-1:0] r_s1, r_s2, r_pending, r_mask;
  logic [N_IRQ-1:0] w_set, w_clr, w_elig, w_id_oh;
  logic [4:0] r_irq_id, w_low;
  logic w_ack, w_unused;
  assign w_unused = ^i_data;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_irq;
      r_s2 <= r_s1;
    end
`ifdef IRQ_EDGE_EN
  logic [N_IRQ-1:0] r_s3;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_s3 <= '0;
    else r_s3 <= r_s2;
  assign w_set = r_s2 & ~r_s3;
`else
  assign w_set = r_s2;
`endif
  assign w_id_oh = N_IRQ'(1) << r_irq_id;
  assign w_elig  = r_pending & r_mask;
  assign w_ack   = (r_state == REQ) && i_int_ack;
  // set is OR-ed in after the clear so a simultaneous set wins
  assign w_clr = ((i_we && i_addr == 32'd0) ? i_data[N_IRQ-1:0] : '0) | (w_ack ? w_id_oh : '0);
  always_comb begin
    w_low = '0;
    for (int k = N_IRQ - 1; k >= 0; k--)
      if (w_elig[k]) w_low = 5'(k);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (i_we && i_addr == 32'd1) r_mask <= i_data[N_IRQ-1:0];
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_irq_id <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |w_elig) r_irq_id <= w_low;
    end
  always_comb begin
    w_next = (r_state == IDLE) ? (|w_elig ? REQ : IDLE) :
             (r_state == REQ)  ? (i_int_ack ? SERVICE : (|(w_elig & w_id_oh) ? REQ : IDLE)) :
                                 (i_eret ? IDLE : SERVICE);
  end
  always_comb begin
    o_interrupt = (r_state == REQ);
    o_busy      = (r_state != IDLE);
    o_irq_id    = r_irq_id;
    o_data      = (i_addr == 32'd0) ? 32'(r_pending) :
                  (i_addr == 32'd1) ? 32'(r_mask) :
                  (i_addr == 32'd2) ? {o_busy, 26'd0, r_irq_id} : 32'd0;
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scoreboard bench; expected request IDs are queued by stimulus and checked by a monitor.
module tb_irq_ctrl;
  localparam int N = 8;
  logic i_clk = 0, i_rst_n = 0, i_we = 0, i_int_ack = 0, i_eret = 0;
  logic [N-1:0] i_irq = '0;
  logic [31:0] i_addr = '0, i_data = '0, o_data, rd_v;
  logic o_interrupt, o_busy, prev_int = 0;
  logic [4:0] o_irq_id;
  int checks = 0, errors = 0;
  int exp_q[$];

  irq_ctrl #(.N_IRQ(N)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_irq(i_irq), .i_we(i_we), .i_addr(i_addr),
    .i_data(i_data), .o_data(o_data), .i_int_ack(i_int_ack), .i_eret(i_eret),
    .o_interrupt(o_interrupt), .o_irq_id(o_irq_id), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_interrupt && !prev_int) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got id %0d expected no request", o_irq_id);
      end else chk("req_id", {27'd0, o_irq_id}, exp_q.pop_front());
    end
    prev_int <= o_interrupt;
  end

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    i_we = 1; i_addr = a; i_data = d;
    tick();
    i_we = 0;
  endtask

  task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    i_addr = a;
    #1;
    rd_v = o_data;
    chk(name, rd_v, exp);
  endtask

  task automatic pulse_irq(input logic [N-1:0] l);
    i_irq = l;
    tick();
    tick();
    i_irq = '0;
  endtask

  task automatic wait_int();
    int n = 0;
    while (!o_interrupt && n < 30) begin
      tick();
      n++;
    end
    chk("wait_int", {31'd0, o_interrupt}, 32'd1);
  endtask

  task automatic ack();
    i_int_ack = 1; tick(); i_int_ack = 0;
  endtask

  task automatic eret();
    i_eret = 1; tick(); i_eret = 0;
  endtask

  task automatic service();
    wait_int(); ack(); eret();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] m, l, lm;
    int n;
    tick(); tick();
    chk("rst_int", {31'd0, o_interrupt}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_id", {27'd0, o_irq_id}, 0);
    chk_rd("rst_pend", 0, 0);
    chk_rd("rst_mask", 1, 0);
    chk_rd("rst_status", 2, 0);
    i_rst_n = 1;
    tick();
    // basic request with exact latency
    wr(1, 32'h04);
    exp_q.push_back(2);
    i_irq = 8'h04; tick(); tick(); i_irq = '0;
    tick(); chk("lat_n2", {31'd0, o_interrupt}, 0);
    tick(); chk("lat_n3", {31'd0, o_interrupt}, 1);
    chk_rd("basic_status", 2, 32'h8000_0002);
    ack();
    chk("basic_ack_int", {31'd0, o_interrupt}, 0);
    chk("basic_ack_busy", {31'd0, o_busy}, 1);
    chk_rd("basic_ack_pend", 0, 0);
    eret();
    chk("basic_eret_busy", {31'd0, o_busy}, 0);
    // priority and masking
    wr(1, 32'hFF);
    exp_q.push_back(1); exp_q.push_back(5);
    pulse_irq(8'h22);
    service(); service();
    wr(1, 32'hFD);
    exp_q.push_back(5);
    pulse_irq(8'h22);
    service();
    tick(); tick();
    chk_rd("prio_masked_pend", 0, 32'h02);
    wr(0, 32'h02);
    chk_rd("prio_clear", 0, 0);
    // withdraw
    wr(1, 32'h08);
    exp_q.push_back(3);
    pulse_irq(8'h08);
    wait_int();
    wr(1, 32'h00);
    chk("wd_still_req", {31'd0, o_interrupt}, 1);
    tick();
    chk("wd_int", {31'd0, o_interrupt}, 0);
    chk("wd_busy", {31'd0, o_busy}, 0);
    chk_rd("wd_pend", 0, 32'h08);
    wr(0, 32'h08);
    // W1C and unused address
    pulse_irq(8'h11);
    tick(); tick();
    chk_rd("w1c_before", 0, 32'h11);
    wr(0, 32'h10);
    chk_rd("w1c_after", 0, 32'h01);
    wr(0, 32'h01);
    wr(3, 32'hFF);
    chk_rd("bad_addr_rd", 3, 0);
    chk_rd("bad_addr_mask", 1, 0);
    wr(1, 32'hFFFF_FF00);
    chk_rd("hi_bits_mask", 1, 0);
    // ignored inputs
    eret();
    chk("eret_idle_busy", {31'd0, o_busy}, 0);
    chk("eret_idle_int", {31'd0, o_interrupt}, 0);
    wr(1, 32'h01);
    exp_q.push_back(0);
    pulse_irq(8'h01);
    wait_int(); ack();
    chk_rd("svc_pend0", 0, 0);
    pulse_irq(8'h01);
    tick(); tick();
    chk_rd("svc_repend", 0, 32'h01);
    ack();
    chk("ack_svc_busy", {31'd0, o_busy}, 1);
    chk("ack_svc_int", {31'd0, o_interrupt}, 0);
    chk_rd("ack_svc_pend", 0, 32'h01);
    exp_q.push_back(0);
    eret();
    chk("eret_busy", {31'd0, o_busy}, 0);
    chk("eret_int", {31'd0, o_interrupt}, 0);
    tick();
    chk("next_req", {31'd0, o_interrupt}, 1);
    i_int_ack = 1; i_eret = 1; tick(); i_int_ack = 0; i_eret = 0;
    chk("ack_eret_busy", {31'd0, o_busy}, 1);
    chk("ack_eret_int", {31'd0, o_interrupt}, 0);
    eret();
    chk("final_eret_busy", {31'd0, o_busy}, 0);
    // randomized: served IDs are the ascending set bits of lines & mask
    for (int it = 0; it < 30; it++) begin
      m = 8'($urandom_range(0, 255));
      l = 8'($urandom_range(1, 255));
      lm = l & m;
      n = 0;
      for (int k = 0; k < N; k++)
        if (lm[k]) begin
          exp_q.push_back(k);
          n++;
        end
      wr(1, {24'd0, m});
      pulse_irq(l);
      repeat (n) service();
      repeat (3) tick();
      chk("rnd_idle", {31'd0, o_interrupt}, 0);
      chk_rd("rnd_pend", 0, {24'd0, l & ~m});
      wr(0, 32'hFF);
    end
`ifdef IRQ_EDGE_EN
    wr(1, 32'h01);
    exp_q.push_back(0);
    i_irq = 8'h01;
    repeat (3) tick();
    service();
    repeat (14) tick();
    chk("edge_hold_int", {31'd0, o_interrupt}, 0);
    chk_rd("edge_hold_pend", 0, 0);
    i_irq = '0;
    repeat (3) tick();
    exp_q.push_back(0);
    i_irq = 8'h01;
    service();
    i_irq = '0;
    tick();
`endif
    // reset mid-request
    wr(1, 32'h01);
    exp_q.push_back(0);
    pulse_irq(8'h01);
    wait_int();
    i_rst_n = 0;
    #1;
    chk("mid_rst_int", {31'd0, o_interrupt}, 0);
    chk("mid_rst_busy", {31'd0, o_busy}, 0);
    chk("mid_rst_id", {27'd0, o_irq_id}, 0);
    chk_rd("mid_rst_pend", 0, 0);
    chk_rd("mid_rst_mask", 1, 0);
    tick();
    i_rst_n = 1;
    tick(); tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
